// File: rtl/sr_latch_arbiter_if.sv
// sr_latch_arbiter_if: request/grant and latch drive signals of the SR latch arbiter
interface sr_latch_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] op;
  logic [NREQ-1:0] gnt;
  logic s_out;
  logic r_out;
  logic q_in;
  logic done;
  logic err;
  modport master (output req, op, q_in, input gnt, s_out, r_out, done, err);
  modport slave (input req, op, q_in, output gnt, s_out, r_out, done, err);
endinterface

// File: rtl/sr_latch_arbiter.sv
// sr_latch_arbiter: round-robin SR latch pulse sequencer; SR_ARB_VERIFY_EN adds a q_in readback CHECK state
module sr_latch_arbiter #(
  parameter int NREQ = 4,
  parameter int PULSE_W = 2,
  parameter int GAP_W = 1
) (
  input logic clk,
  input logic rst,
  sr_latch_arbiter_if.slave bus
);
  localparam int MX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW = $clog2(MX) + 1;
  localparam int PTRW = $clog2(NREQ);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] GAP = 2'd2;
`ifdef SR_ARB_VERIFY_EN
  localparam logic [1:0] CHECK = 2'd3;
`endif
  logic [1:0] state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PTRW-1:0] ptr, ptr_n, win;
  logic [NREQ-1:0] gnt_n;
  logic op_r, op_n, found;
  always_comb begin
    found = 1'b0;
    win = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req[(int'(ptr) + i) % NREQ]) begin
        found = 1'b1;
        win = PTRW'((int'(ptr) + i) % NREQ);
      end
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    ptr_n = ptr;
    op_n = op_r;
    gnt_n = bus.gnt;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (found) begin
          state_n = PULSE;
          gnt_n = NREQ'(1) << win;
          op_n = bus.op[win];
          ptr_n = (win == PTRW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
      end
      PULSE: if (cnt == CW'(PULSE_W - 1)) begin
        state_n = GAP;
        cnt_n = '0;
      end
      GAP: if (cnt == CW'(GAP_W - 1)) begin
`ifdef SR_ARB_VERIFY_EN
        state_n = CHECK;
`else
        state_n = IDLE;
`endif
        cnt_n = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
    if (state_n == IDLE) gnt_n = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      op_r <= 1'b0;
      bus.gnt <= '0;
      bus.s_out <= 1'b0;
      bus.r_out <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ptr <= ptr_n;
      op_r <= op_n;
      bus.gnt <= gnt_n;
      bus.s_out <= (state_n == PULSE) && op_n;
      bus.r_out <= (state_n == PULSE) && !op_n;
`ifdef SR_ARB_VERIFY_EN
      bus.done <= state_n == CHECK;
      bus.err <= (state_n == CHECK) && (bus.q_in != op_n);
`else
      bus.done <= (state_n == GAP) && (cnt_n == CW'(GAP_W - 1));
      bus.err <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_sr_latch_arbiter.sv
// tb_sr_latch_arbiter: randomized check of sr_latch_arbiter against a service-position reference model
module tb_sr_latch_arbiter;
  localparam int NREQ = 4;
  localparam int PULSE_W = 2;
  localparam int GAP_W = 1;
`ifdef SR_ARB_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif
  localparam int L = PULSE_W + GAP_W + VER;
  logic clk;
  logic rst;
  int n_chk;
  int n_pass;
  int p;
  int mptr;
  int mw;
  bit mop;
  bit mq;
  sr_latch_arbiter_if #(.NREQ(NREQ)) bus ();
  sr_latch_arbiter #(.NREQ(NREQ), .PULSE_W(PULSE_W), .GAP_W(GAP_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask
  task automatic model(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] ov, input logic q);
    if (r) begin
      p = 0;
      mptr = 0;
    end else if (p == 0) begin
      if (rq != 0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (rq[(mptr + i) % NREQ]) begin
            mw = (mptr + i) % NREQ;
            break;
          end
        end
        mop = ov[mw];
        mptr = (mw + 1) % NREQ;
        p = 1;
      end
    end else if (p == L) begin
      p = 0;
    end else begin
      p++;
      if (p == L) mq = q;
    end
  endtask
  task automatic step(input string tag, input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] ov, input logic q);
    logic [NREQ-1:0] eg;
    logic es, er, ed, ee;
    @(negedge clk);
    rst = r;
    bus.req = rq;
    bus.op = ov;
    bus.q_in = q;
    @(posedge clk);
    model(r, rq, ov, q);
    eg = (p != 0) ? NREQ'(1 << mw) : '0;
    es = (p >= 1) && (p <= PULSE_W) && mop;
    er = (p >= 1) && (p <= PULSE_W) && !mop;
    ed = (p == L);
    ee = (VER == 1) && (p == L) && (mq != mop);
    #1;
    check(tag, 16'({bus.gnt, bus.s_out, bus.r_out, bus.done, bus.err}), 16'({eg, es, er, ed, ee}));
    check({tag, "_excl"}, 16'(bus.s_out & bus.r_out), 16'd0);
  endtask
  initial begin
    n_chk = 0;
    n_pass = 0;
    p = 0;
    mptr = 0;
    mw = 0;
    mop = 0;
    mq = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.op = '0;
    bus.q_in = 1'b0;
    repeat (2) step("reset", 1, 4'b0000, 4'b0000, 0);
    repeat (5) step("single_set", 0, 4'b0001, 4'b0001, 1);
    step("reset", 1, 4'b0000, 4'b0000, 0);
    repeat (4 * (L + 1) + 2) step("rr_all", 0, 4'b1111, 4'b0000, 0);
    step("reset", 1, 4'b0000, 4'b0000, 0);
    repeat (L + 1) step("serve2", 0, 4'b0100, 4'b0000, 0);
    repeat (L + 2) step("wrap", 0, 4'b0101, 4'b0000, 0);
    step("reset", 1, 4'b0000, 4'b0000, 0);
    step("pre_rst", 0, 4'b0001, 4'b0001, 0);
    step("mid_rst", 1, 4'b0001, 4'b0001, 0);
    repeat (L + 1) step("after_rst", 0, 4'b1111, 4'b0000, 0);
    step("drop_req", 0, 4'b0010, 4'b1111, 0);
    repeat (L + 1) step("drop_req", 0, 4'b0000, 4'b0000, 1);
    repeat (L + 1) step("q_bad", 0, 4'b0001, 4'b0001, 0);
    repeat (L + 1) step("q_good", 0, 4'b0001, 4'b0001, 1);
    for (int n = 0; n < 2000; n++)
      step("random", $urandom_range(0, 63) == 0, NREQ'($urandom), NREQ'($urandom), 1'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sr_latch_arbiter.md
# sr_latch_arbiter

Synchronous arbiter and pulse sequencer that shares one cross-coupled NOR SR latch among `NREQ` requesters. Each requester asks for a set or a reset; the block grants one requester at a time (round-robin) and drives a clean `s_out`/`r_out` pulse of fixed width, followed by a mandatory idle gap. `s_out` and `r_out` are never high together, so the latch never sees the forbidden S=R=1 input. It sits between the clocked control logic and the asynchronous latch primitive.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; valid range 2..8.
- `PULSE_W`, 2: cycles `s_out`/`r_out` is held high; must be ≥1.
- `GAP_W`, 1: cycles with both `s_out` and `r_out` low after each pulse; must be ≥1.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  NREQ  per-requester request, level; hold until `done` with own `gnt`.
- `op`  in  NREQ  per-requester operation: 1 = set, 0 = reset; sampled at the grant.
- `gnt`  out  NREQ  one-hot grant; held for the whole service.
- `s_out`  out  1  set drive to the latch.
- `r_out`  out  1  reset drive to the latch.
- `q_in`  in  1  latch `q` readback; used only with `SR_ARB_VERIFY_EN`.
- `done`  out  1  one-cycle completion strobe for the granted requester.
- `err`  out  1  one-cycle readback mismatch strobe, coincident with `done`.

## Operation
- States: `IDLE`, `PULSE`, `GAP`, and `CHECK` (`CHECK` exists only with `SR_ARB_VERIFY_EN`).
- `IDLE`: if `req` is nonzero, pick a winner round-robin:
  - Search starts at pointer `ptr` and proceeds upward modulo `NREQ`.
  - Register `gnt` one-hot for the winner and latch its `op` bit into `op_r`.
  - Set `ptr` to (winner+1) mod `NREQ`.
  - Go to `PULSE` with the cycle counter cleared.
- `PULSE`: drive `s_out = op_r` and `r_out = ~op_r` for `PULSE_W` cycles, then go to `GAP`.
- `GAP`: both outputs low for `GAP_W` cycles.
  - Without the macro, `done` pulses in the last `GAP` cycle and the state returns to `IDLE`.
  - With the macro, the state goes to `CHECK` instead.
- `CHECK` (one cycle): `done` = 1, `err` = (`q_in` != `op_r`), then return to `IDLE`.
- `gnt` clears on the cycle after `done`.
- Requests are not abortable. Dropping `req` after the grant does not shorten the service. `req` and `op` changes during service are ignored.
- Requests from non-granted requesters wait. There is no queueing beyond the level request.
- Counter width is clog2(max(`PULSE_W`, `GAP_W`)) + 1. Counter wrap never occurs within a state.
- Invariant: `s_out & r_out` = 0 in every cycle, including reset and state transitions.

## Timing
- Reset: an edge with `rst` = 1 forces state `IDLE`, `ptr` = 0, and `gnt`, `s_out`, `r_out`, `done`, `err` all 0 at that edge. Reset mid-pulse truncates the pulse immediately. The latch keeps whatever state it reached.
- Latency: `req` seen in `IDLE` at edge T gives `gnt` and pulse high from T+1 through T+`PULSE_W`. The gap runs from T+`PULSE_W`+1 to T+`PULSE_W`+`GAP_W`.
- `done` timing:
  - Without the macro: at cycle T+`PULSE_W`+`GAP_W`.
  - With the macro: at cycle T+`PULSE_W`+`GAP_W`+1.
- Back-to-back: the block returns to `IDLE` for exactly one cycle between services. The minimum service period is `PULSE_W`+`GAP_W`+1 cycles (+1 with the macro).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `SR_ARB_VERIFY_EN` defined:
  - `CHECK` state is compiled in, and `q_in` is compared against `op_r` one cycle after the gap.
  - `err` reports a mismatch.
  - Service is one cycle longer.
- Undefined:
  - No `CHECK` state; `q_in` is unused.
  - `err` is tied to 0 and `done` is issued in the last `GAP` cycle.

## Test plan
- Reset, then `req`=0001, `op`=0001, defaults: `gnt`=0001 and `s_out`=1 for 2 cycles, `r_out`=0 throughout, then 1 gap cycle, then `done`; `ptr`=1.
- `req`=1111 held continuously, all `op`=0: grants in order 0001, 0010, 0100, 1000, 0001. Each service shows `r_out` pulsing 2 cycles. `s_out&r_out` is never 1.
- After serving requester 2, `req`=0101: next grant is 0100? No — `ptr`=3, so the search wraps and grants 0001.
- Macro on, `op`=1 granted, `q_in` forced to 0: `done`=1 and `err`=1 in the same cycle, 4 cycles after grant start. With `q_in`=1, `err`=0.
- `rst`=1 during the second `PULSE` cycle: at that edge `s_out`, `gnt`, and `done` go to 0 and state is `IDLE`. A new request is granted to requester 0 (`ptr` reset).
- Granted requester drops `req` mid-pulse: full `PULSE_W`+`GAP_W` service still completes and `done` is still issued.
